// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and fetch sequencer. Advances the PC on accepted fetches,
//   applies branch redirects (directly, or deferred through a pending-target
//   register when a stall coincides with a taken branch), and issues a
//   one-cycle flush pulse whenever a redirect lands on pc_out.
//
// Parameters
//   XLEN          datapath / PC width
//   RESET_VECTOR  PC value loaded on reset
//
// Ports
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   to_branch     branch-taken decision for the instruction at pc_out
//   branch_offset sign-extended, pre-shifted byte offset
//   stall         freezes the PC and parks the sequencer in HOLD
//   imem_ready    instruction memory accepts the current fetch
//   pc_out        current fetch address (registered)
//   pc_plus4      pc_out + 4 (combinational)
//   fetch_req     fetch request to instruction memory (registered)
//   flush         one-cycle pulse after a branch target is loaded
//   misalign_err  one-cycle pulse after a misaligned target is suppressed
//
// Build option
//   MISALIGN_CHECK_EN  when defined, targets with target[1:0] != 0 are
//                      suppressed (PC falls through to pc_plus4) and flagged
//                      on misalign_err. When undefined, targets are used
//                      as-is and misalign_err stays 0.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            to_branch,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            stall,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_req,
    output logic            flush,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pend_target;
    logic            pend_valid;
    logic            target_bad;
    logic            take_branch;
    logic            bad_branch;

    assign pc_plus4 = pc_out + XLEN'(4);
    assign target   = pc_out + branch_offset;

`ifdef MISALIGN_CHECK_EN
    assign target_bad = (target[1:0] != 2'b00);
`else
    assign target_bad = 1'b0;
`endif

    // A misaligned target is treated as not-taken plus an error pulse.
    assign take_branch = to_branch & ~target_bad;
    assign bad_branch  = to_branch &  target_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc_out       <= RESET_VECTOR;
            pend_target  <= '0;
            pend_valid   <= 1'b0;
            fetch_req    <= 1'b0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                end
                FETCH: begin
                    if (stall) begin
                        // Stall wins over accept; a taken branch is parked
                        // until the stall releases.
                        state     <= HOLD;
                        fetch_req <= 1'b0;
                        if (take_branch) begin
                            pend_target <= target;
                            pend_valid  <= 1'b1;
                        end
                        misalign_err <= bad_branch;
                    end else if (imem_ready) begin
                        if (take_branch) begin
                            pc_out <= target;
                            flush  <= 1'b1;
                        end else begin
                            pc_out <= pc_plus4;
                        end
                        misalign_err <= bad_branch;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state     <= FETCH;
                        fetch_req <= 1'b1;
                        if (pend_valid) begin
                            pc_out     <= pend_target;
                            pend_valid <= 1'b0;
                            flush      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= BOOT;
                    fetch_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int unsigned     XLEN = 64;
    localparam logic [XLEN-1:0] RV   = 64'h1000;

    logic            clk;
    logic            rst_n;
    logic            to_branch;
    logic [XLEN-1:0] branch_offset;
    logic            stall;
    logic            imem_ready;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_req;
    logic            flush;
    logic            misalign_err;

    pc_fetch_unit #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .to_branch    (to_branch),
        .branch_offset(branch_offset),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .fetch_req    (fetch_req),
        .flush        (flush),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Behavioural model: "booting", "running" and a queue of deferred targets.
    logic [XLEN-1:0] m_pc;
    bit              m_booting;
    bit              m_running;
    logic [XLEN-1:0] m_pend[$];
    bit              m_flush;
    bit              m_err;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc      = RV;
        m_booting = 1;
        m_running = 0;
        m_pend.delete();
        m_flush   = 0;
        m_err     = 0;
    endtask

    function automatic bit misaligned(input logic [XLEN-1:0] t);
`ifdef MISALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Applies one rising edge worth of the rules to the model.
    task automatic model_edge();
        logic [XLEN-1:0] tgt;
        bit              br_ok;
        bit              br_bad;
        tgt     = m_pc + branch_offset;
        br_ok   = to_branch && !misaligned(tgt);
        br_bad  = to_branch &&  misaligned(tgt);
        m_flush = 0;
        m_err   = 0;
        if (m_booting) begin
            m_booting = 0;
            m_running = 1;
        end else if (m_running) begin
            if (stall) begin
                m_running = 0;
                if (br_ok) m_pend.push_back(tgt);
                m_err = br_bad;
            end else if (imem_ready) begin
                m_pc    = br_ok ? tgt : m_pc + 4;
                m_flush = br_ok;
                m_err   = br_bad;
            end
        end else if (!stall) begin
            m_running = 1;
            if (m_pend.size() > 0) begin
                m_pc    = m_pend.pop_front();
                m_flush = 1;
            end
        end
    endtask

    task automatic model_cmp();
        chk("pc_out",       pc_out,       m_pc);
        chk("pc_plus4",     pc_plus4,     m_pc + 4);
        chk("fetch_req",    {63'd0, fetch_req},    {63'd0, m_running});
        chk("flush",        {63'd0, flush},        {63'd0, m_flush});
        chk("misalign_err", {63'd0, misalign_err}, {63'd0, m_err});
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic drive(input bit br, input logic [XLEN-1:0] off, input bit st, input bit rdy);
        to_branch     = br;
        branch_offset = off;
        stall         = st;
        imem_ready    = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, '0, 0, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        model_cmp();
        chk("reset pc",        pc_out,   64'h1000);
        chk("reset pc_plus4",  pc_plus4, 64'h1004);
        chk("reset fetch_req", {63'd0, fetch_req}, 64'd0);
        rst_n = 1'b1;

        // Boot then sequential fetch
        step();
        chk("boot pc",  pc_out, 64'h1000);
        chk("boot req", {63'd0, fetch_req}, 64'd1);
        step();
        chk("seq pc 1004", pc_out, 64'h1004);
        step();
        chk("seq pc 1008", pc_out, 64'h1008);
        chk("seq flush",   {63'd0, flush}, 64'd0);

        // Unstalled backward branch
        drive(1, -64'sd8, 0, 1);
        step();
        chk("br pc",    pc_out, 64'h1000);
        chk("br flush", {63'd0, flush}, 64'd1);
        drive(0, '0, 0, 1);
        step();
        chk("br flush drop", {63'd0, flush}, 64'd0);
        chk("br pc next",    pc_out, 64'h1004);

        // Move to 0x2000, then stalled branch
        drive(1, 64'hFFC, 0, 1);
        step();
        chk("to 2000", pc_out, 64'h2000);
        drive(1, 64'h40, 1, 1);
        step();
        drive(1, 64'h100, 1, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold pc",  pc_out, 64'h2000);
            chk("hold req", {63'd0, fetch_req}, 64'd0);
        end
        drive(0, '0, 0, 1);
        step();
        chk("pend pc",    pc_out, 64'h2040);
        chk("pend flush", {63'd0, flush}, 64'd1);
        step();
        chk("pend flush drop", {63'd0, flush}, 64'd0);

        // Move to 0x3000 (from 0x2044), then memory not ready
        drive(1, 64'hFBC, 0, 1);
        step();
        chk("to 3000", pc_out, 64'h3000);
        drive(0, '0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("nrdy pc",  pc_out, 64'h3000);
            chk("nrdy req", {63'd0, fetch_req}, 64'd1);
        end
        drive(0, '0, 0, 1);
        step();
        chk("rdy pc", pc_out, 64'h3004);

        // Wrap: jump to top word, then fall through to 0
        drive(1, -64'sd12296, 0, 1);
        step();
        chk("top pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, '0, 0, 1);
        step();
        chk("wrap pc", pc_out, 64'h0);

`ifdef MISALIGN_CHECK_EN
        drive(1, 64'h100, 0, 1);
        step();
        drive(1, 64'h6, 0, 1);
        step();
        chk("mis pc",  pc_out, 64'h104);
        chk("mis err", {63'd0, misalign_err}, 64'd1);
        chk("mis flush", {63'd0, flush}, 64'd0);
        drive(0, '0, 0, 1);
        step();
        chk("mis err drop", {63'd0, misalign_err}, 64'd0);
`endif

        // Reset during HOLD with a pending branch
        drive(1, 64'h800, 1, 1);
        step();
        drive(0, '0, 1, 1);
        step();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("async rst pc",  pc_out, 64'h1000);
        chk("async rst req", {63'd0, fetch_req}, 64'd0);
        @(negedge clk);
        model_cmp();
        rst_n = 1'b1;
        drive(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post rst flush", {63'd0, flush}, 64'd0);
        end
        chk("post rst pc", pc_out, 64'h100C);

        // Randomised traffic against the model
        for (int unsigned i = 0; i < 3000; i++) begin
            logic [XLEN-1:0] off;
            case ($urandom % 4)
                0: off = XLEN'($signed(int'($urandom_range(0, 255)) - 128) * 4);
                1: off = {$urandom, $urandom} & ~64'h3;
                2: off = {$urandom, $urandom};
                default: off = XLEN'($signed(int'($urandom_range(0, 63)) - 32));
            endcase
            drive(($urandom % 3) == 0, off, ($urandom % 4) == 0, ($urandom % 4) != 0);
            if (($urandom % 400) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                model_cmp();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
